// File: rtl/muldiv_sequencer_if.sv
// EX-stage to multiply/divide unit handshake: one-shot start with operands, stall/done/result back.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M mul/div: done_o WIDTH+1 cycles after accept (1 cycle for divide special cases).
// Holds EX via stall_o while busy; MULDIV_FAST_MUL_EN makes MUL* single-cycle with a combinational multiplier.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             sign_a_q, sign_a_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   mul_sum, div_diff;
  logic [W2-1:0]    iter_acc;

  function automatic logic [WIDTH-1:0] pick_result(input logic [2:0]    op,
                                                   input logic [W2-1:0] acc,
                                                   input logic          neg,
                                                   input logic          sign_a);
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quot, rem;
    prod = neg ? -acc : acc;
    quot = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // Remainder follows the dividend's sign, independent of the divisor.
    rem  = sign_a ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    case (op)
      3'b000:                 pick_result = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: pick_result = prod[W2-1:WIDTH];
      3'b100, 3'b101:         pick_result = quot;
      default:                pick_result = rem;
    endcase
  endfunction

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.op_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sa    = a_signed & bus.a_i[WIDTH-1];
  assign sb    = b_signed & bus.b_i[WIDTH-1];
  assign a_mag = sa ? -bus.a_i : bus.a_i;
  assign b_mag = sb ? -bus.b_i : bus.b_i;

  assign div_zero = bus.op_i[2] & (bus.b_i == '0);
  assign div_ovf  = bus.op_i[2] & ~bus.op_i[0] & (bus.a_i == {1'b1, {(WIDTH-1){1'b0}}})
                  & (bus.b_i == '1);
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = bus.op_i[1] ? bus.a_i : '1;
    else
      special_res = bus.op_i[1] ? '0 : bus.a_i;
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_diff = acc_q[W2-1:WIDTH-1] - {1'b0, b_q};
  always_comb begin
    iter_acc = {mul_sum, acc_q[WIDTH-1:1]};
    if (op_q[2]) begin
      if (div_diff[WIDTH])
        iter_acc = {acc_q[W2-2:0], 1'b0};
      else
        iter_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [W2-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    acc_d    = acc_q;
    b_d      = b_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d     = bus.op_i;
          neg_d    = sa ^ sb;
          sign_a_d = sa;
          b_d      = b_mag;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          cnt_d    = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!bus.op_i[2]) begin
            result_d = pick_result(bus.op_i, fast_prod, sa ^ sb, sa);
            done_d   = 1'b1;
            state_d  = DONE;
          end
`endif
          else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = iter_acc;
        cnt_d = cnt_q + 1'b1;
        if (bus.flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = pick_result(op_q, iter_acc, neg_q, sign_a_q);
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.stall_o  = !rst && ((state_q == RUN) ||
                        ((state_q == IDLE) && bus.start_i && !bus.flush_i));
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit for the EX stage of the pipelined CPU.
- Accepts one operation from the decoder/EX path, holds the pipeline via `stall_o` while it iterates, then presents a registered result for one cycle.
- Shares nothing: exactly one requester (EX stage); the hazard logic ORs `stall_o` into its pipeline stall.

Parameters:
- WIDTH, 32, operand/result width (only 32 is verified)
- CNT_W, 6, iteration counter width; must hold WIDTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  EX holds a valid M-extension instruction
- op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a_i  in  WIDTH  rs1 operand (forwarded)
- b_i  in  WIDTH  rs2 operand (forwarded)
- flush_i  in  1  synchronous abort (branch/jump flush of EX)
- stall_o  out  1  pipeline hold request
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  WIDTH  registered result

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; counter, operand registers, done_o and result_o all 0.
  - stall_o=0 while in reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i & !flush_i, latch op_i, |a|, |b| and sign flags, then go to RUN with counter=0.
  - Special-case divides go straight to DONE instead.
  - stall_o = start_i & !flush_i, combinational, in the accept cycle.
- Signed ops take magnitudes:
  - a is signed for MUL/MULH/MULHSU/DIV/REM.
  - b is signed for MUL/MULH/DIV/REM.
- RUN:
  - One iteration per cycle, WIDTH iterations.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - stall_o=1.
  - After iteration WIDTH-1:
    - Apply the sign fix.
    - Select the low half (MUL), high half (MULH*), quotient (DIV*) or remainder (REM*).
    - Register the selection into result_o and go to DONE.
- Sign fix:
  - Product negated if sign_a^sign_b.
  - Quotient negated if sign_a^sign_b.
  - Remainder takes the sign of the dividend.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle, so the pipeline advances.
  - Next state IDLE.
  - start_i is ignored in DONE.
- Latency:
  - Accept at cycle 0, done_o at cycle WIDTH+1 (33).
  - stall_o is high for cycles 0..32.
- Divide by zero (b=0):
  - IDLE goes straight to DONE; done_o at cycle 1.
  - DIV/DIVU return all-ones.
  - REM/REMU return a.
- Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF):
  - Goes straight to DONE.
  - DIV returns 0x80000000; REM returns 0.
- flush_i:
  - In RUN, the next state is IDLE with no done_o; result_o is unchanged; stall_o drops the cycle after flush.
  - In IDLE, flush_i blocks acceptance.
  - In DONE, done_o still pulses.
- result_o holds its last value outside DONE.
- Asserting rst mid-operation returns to IDLE immediately; no done_o follows.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL* ops compute the full 2*WIDTH signed/unsigned product with a single combinational multiplier.
  - They go IDLE->DONE, so done_o comes at cycle 1 and stall_o is high only for cycle 0.
  - Divides are unchanged.
- Undefined: the 32-iteration shift-add path is used for all MUL* ops; there is no multiplier inferred.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> stall_o high for 33 cycles, done_o at cycle 33, result_o=0xFFFFFFEB. With MULDIV_FAST_MUL_EN: done_o at cycle 1, same value.
- MULH a=b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD at cycle 33; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF with done_o at cycle 1; REM 100/0 -> 100; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Start DIV, assert flush_i at cycle 10 -> no done_o, stall_o=0 from cycle 11. A new MUL 3*5 accepted at cycle 12 -> 15 with done_o at cycle 45.
- Assert rst at cycle 5 of a MUL -> stall_o, done_o and result_o all 0 immediately; no done_o for that op after reset is released.
